// File: rtl/bsg_demux_one_hot_buf_width_p4_els_p2.sv
// ---------------------------------------------------------------------------
// bsg_demux_one_hot_buf_width_p4_els_p2
//
// Purpose:
//   Steers a single valid/ready input stream into one of two output lanes
//   chosen by a one-hot select. Each lane owns an independent 2-entry FIFO,
//   so a stall on one lane never holds up traffic bound for the other.
//   Beats accepted with a malformed select (none or both lanes) are dropped
//   and latch a sticky error flag. The error flag does not stop traffic.
//
// Ports:
//   clk_i          in   1   sole clock, rising edge
//   reset_n_i      in   1   synchronous active-low reset
//   v_i            in   1   input payload valid
//   data_i         in   4   input payload
//   sel_one_hot_i  in   2   destination lane, bit k selects lane k
//   ready_o        out  1   beat accepted when v_i & ready_o
//   v_o            out  2   per-lane output valid
//   data_o         out  8   lane k payload on data_o[4k+3:4k]
//   yumi_i         in   2   per-lane consume strobe
//   err_o          out  1   sticky malformed-select flag
// ---------------------------------------------------------------------------
module bsg_demux_one_hot_buf_width_p4_els_p2 (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                v_i,
    input  logic [3:0]          data_i,
    input  logic [1:0]          sel_one_hot_i,
    output logic                ready_o,
    output logic [1:0]          v_o,
    output logic [7:0]          data_o,
    input  logic [1:0]          yumi_i,
    output logic                err_o
);

    localparam int width_p    = 4;
    localparam int els_p      = 2;
    localparam int lg_depth_p = 1;
    localparam int depth_lp   = 2 ** lg_depth_p;

    // Count value meaning "lane full".
    localparam logic [lg_depth_p:0] full_count_lp = 2'd2;

    // True when exactly one bit of the select is set.
    function automatic logic is_one_hot(input logic [els_p-1:0] sel);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < els_p; i++) begin
            if (sel[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end else begin
                multi = multi;
            end
        end
        return seen & ~multi;
    endfunction

    // Per-lane FIFO state.
    logic [lg_depth_p:0]   count_r [els_p];
    logic [els_p-1:0]      wptr_r;
    logic [els_p-1:0]      rptr_r;
    logic [width_p-1:0]    mem_r   [els_p][depth_lp];
    logic                  err_r;

    // Derived handshake terms.
    logic                  sel_ok_s;
    logic                  room_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  accept_bad_s;
    logic [els_p-1:0]      enq_s;
    logic [els_p-1:0]      deq_s;

    // Space check for the selected lane; uses registered counts only so a
    // same-cycle dequeue on a full lane cannot open the input.
    always_comb begin
        sel_ok_s = is_one_hot(sel_one_hot_i);
        room_s   = 1'b0;
        for (int k = 0; k < els_p; k++) begin
            if (sel_one_hot_i[k] && (count_r[k] != full_count_lp)) begin
                room_s = 1'b1;
            end else begin
                room_s = room_s;
            end
        end
    end

    // Input handshake: malformed selects are always accepted (then dropped)
    // so a bad source cannot wedge the block; reset holds ready low.
    always_comb begin
        if (!reset_n_i) begin
            ready_s = 1'b0;
        end else if (!sel_ok_s) begin
            ready_s = 1'b1;
        end else begin
            ready_s = room_s;
        end
        accept_s     = v_i & ready_s;
        accept_bad_s = accept_s & ~sel_ok_s;
    end

    // Per-lane enqueue/dequeue strobes; a yumi on an empty lane is ignored.
    always_comb begin
        enq_s = {els_p{1'b0}};
        deq_s = {els_p{1'b0}};
        for (int k = 0; k < els_p; k++) begin
            enq_s[k] = accept_s & sel_ok_s & sel_one_hot_i[k];
            deq_s[k] = reset_n_i & yumi_i[k] & (count_r[k] != 2'd0);
        end
    end

    // Pointer, occupancy and error-flag state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < els_p; k++) begin
                count_r[k] <= 2'd0;
            end
            wptr_r <= {els_p{1'b0}};
            rptr_r <= {els_p{1'b0}};
            err_r  <= 1'b0;
        end else begin
            for (int k = 0; k < els_p; k++) begin
                if (enq_s[k]) begin
                    wptr_r[k] <= ~wptr_r[k];
                end
                if (deq_s[k]) begin
                    rptr_r[k] <= ~rptr_r[k];
                end
                // Simultaneous push and pop leaves occupancy unchanged.
                case ({enq_s[k], deq_s[k]})
                    2'b10:   count_r[k] <= count_r[k] + 2'd1;
                    2'b01:   count_r[k] <= count_r[k] - 2'd1;
                    default: count_r[k] <= count_r[k];
                endcase
            end
            if (accept_bad_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Payload storage; not reset, writes are already gated off during reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < els_p; k++) begin
            if (enq_s[k]) begin
                mem_r[k][wptr_r[k]] <= data_i;
            end
        end
    end

    // Output view: valid from occupancy, data from the head entry.
    always_comb begin
        v_o    = {els_p{1'b0}};
        data_o = {(width_p*els_p){1'b0}};
        for (int k = 0; k < els_p; k++) begin
            v_o[k]                        = (count_r[k] != 2'd0);
            data_o[k*width_p +: width_p]  = mem_r[k][rptr_r[k]];
        end
    end

    // Output drivers.
    always_comb begin
        ready_o = ready_s;
        err_o   = err_r;
    end

endmodule

// File: tb/tb_bsg_demux_one_hot_buf_width_p4_els_p2.sv
module tb_bsg_demux_one_hot_buf_width_p4_els_p2;

    logic       clk;
    logic       reset_n_i;
    logic       v_i;
    logic [3:0] data_i;
    logic [1:0] sel_one_hot_i;
    logic       ready_o;
    logic [1:0] v_o;
    logic [7:0] data_o;
    logic [1:0] yumi_i;
    logic       err_o;

    int checks;
    int errors;

    typedef struct {
        logic       rst_n;
        logic       v;
        logic [3:0] data;
        logic [1:0] sel;
        logic [1:0] yumi;
        logic       exp_ready;
        logic [1:0] exp_v;
        logic [3:0] exp_d0;
        logic [3:0] exp_d1;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    bsg_demux_one_hot_buf_width_p4_els_p2 dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n_i),
        .v_i           (v_i),
        .data_i        (data_i),
        .sel_one_hot_i (sel_one_hot_i),
        .ready_o       (ready_o),
        .v_o           (v_o),
        .data_o        (data_o),
        .yumi_i        (yumi_i),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst_n, input logic v, input logic [3:0] data,
                                input logic [1:0] sel, input logic [1:0] yumi,
                                input logic exp_ready, input logic [1:0] exp_v,
                                input logic [3:0] exp_d0, input logic [3:0] exp_d1,
                                input logic exp_err);
        vec_t r;
        r.rst_n = rst_n; r.v = v; r.data = data; r.sel = sel; r.yumi = yumi;
        r.exp_ready = exp_ready; r.exp_v = exp_v;
        r.exp_d0 = exp_d0; r.exp_d1 = exp_d1; r.exp_err = exp_err;
        return r;
    endfunction

    task automatic apply(input int idx, input vec_t t);
        @(negedge clk);
        reset_n_i     = t.rst_n;
        v_i           = t.v;
        data_i        = t.data;
        sel_one_hot_i = t.sel;
        yumi_i        = t.yumi;
        #1;
        checks++;
        if (ready_o !== t.exp_ready) begin
            errors++;
            $display("FAIL ready vec %0d: got %b want %b", idx, ready_o, t.exp_ready);
        end
        // A consume strobe must only target a lane that currently shows valid.
        checks++;
        if (t.rst_n && ((t.yumi & ~v_o) !== 2'b00)) begin
            errors++;
            $display("FAIL illegal_yumi vec %0d: yumi %b while v_o %b", idx, t.yumi, v_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (v_o !== t.exp_v) begin
            errors++;
            $display("FAIL v_o vec %0d: got %b want %b", idx, v_o, t.exp_v);
        end
        if (t.exp_v[0]) begin
            checks++;
            if (data_o[3:0] !== t.exp_d0) begin
                errors++;
                $display("FAIL data0 vec %0d: got %h want %h", idx, data_o[3:0], t.exp_d0);
            end
        end
        if (t.exp_v[1]) begin
            checks++;
            if (data_o[7:4] !== t.exp_d1) begin
                errors++;
                $display("FAIL data1 vec %0d: got %h want %h", idx, data_o[7:4], t.exp_d1);
            end
        end
        checks++;
        if (err_o !== t.exp_err) begin
            errors++;
            $display("FAIL err vec %0d: got %b want %b", idx, err_o, t.exp_err);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n_i     = 1'b0;
        v_i           = 1'b0;
        data_i        = 4'h0;
        sel_one_hot_i = 2'b00;
        yumi_i        = 2'b00;

        //                  rst  v     data   sel    yumi   rdy   v_o    d0     d1     err
        // reset
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0));
        // single beat to lane 0, one-cycle latency
        vecs.push_back(mk(1'b1, 1'b1, 4'hA, 2'b01, 2'b00, 1'b1, 2'b01, 4'hA, 4'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 4'h0, 2'b01, 2'b01, 1'b1, 2'b00, 4'h0, 4'h0, 1'b0));
        // lane 1 fill, third beat refused, full lane stays not-ready on pop
        vecs.push_back(mk(1'b1, 1'b1, 4'h1, 2'b10, 2'b00, 1'b1, 2'b10, 4'h0, 4'h1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 4'h2, 2'b10, 2'b00, 1'b1, 2'b10, 4'h0, 4'h1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 4'h3, 2'b10, 2'b00, 1'b0, 2'b10, 4'h0, 4'h1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 4'h0, 2'b10, 2'b10, 1'b0, 2'b10, 4'h0, 4'h2, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 4'h0, 2'b10, 2'b10, 1'b1, 2'b00, 4'h0, 4'h0, 1'b0));
        // lane 0 full and stalled, lane 1 still accepts
        vecs.push_back(mk(1'b1, 1'b1, 4'h7, 2'b01, 2'b00, 1'b1, 2'b01, 4'h7, 4'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 4'h8, 2'b01, 2'b00, 1'b1, 2'b01, 4'h7, 4'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 4'h9, 2'b01, 2'b00, 1'b0, 2'b01, 4'h7, 4'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 4'hC, 2'b10, 2'b00, 1'b1, 2'b11, 4'h7, 4'hC, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 4'h0, 2'b01, 2'b11, 1'b0, 2'b01, 4'h8, 4'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 4'h0, 2'b01, 2'b01, 1'b1, 2'b00, 4'h0, 4'h0, 1'b0));
        // simultaneous enqueue/dequeue on lane 0 across pointer wrap
        vecs.push_back(mk(1'b1, 1'b1, 4'h4, 2'b01, 2'b00, 1'b1, 2'b01, 4'h4, 4'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 4'h5, 2'b01, 2'b01, 1'b1, 2'b01, 4'h5, 4'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 4'h6, 2'b01, 2'b01, 1'b1, 2'b01, 4'h6, 4'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 4'h7, 2'b01, 2'b01, 1'b1, 2'b01, 4'h7, 4'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 4'h8, 2'b01, 2'b01, 1'b1, 2'b01, 4'h8, 4'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 4'h0, 2'b01, 2'b01, 1'b1, 2'b00, 4'h0, 4'h0, 1'b0));
        // malformed selects: accepted, dropped, sticky error, traffic continues
        vecs.push_back(mk(1'b1, 1'b1, 4'hF, 2'b11, 2'b00, 1'b1, 2'b00, 4'h0, 4'h0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 4'hE, 2'b00, 2'b00, 1'b1, 2'b00, 4'h0, 4'h0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 4'h3, 2'b01, 2'b00, 1'b1, 2'b01, 4'h3, 4'h0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 4'hB, 2'b10, 2'b00, 1'b1, 2'b11, 4'h3, 4'hB, 1'b1));
        // mid-operation reset with input and yumi present
        vecs.push_back(mk(1'b0, 1'b1, 4'hD, 2'b01, 2'b11, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 4'h0, 2'b01, 2'b00, 1'b1, 2'b00, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 4'h6, 2'b01, 2'b00, 1'b1, 2'b01, 4'h6, 4'h0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Lane independence: lane 1 fills and stalls while lane 0 streams.
        apply(100, mk(1'b1, 1'b1, 4'hA, 2'b10, 2'b00, 1'b1, 2'b11, 4'h6, 4'hA, 1'b0));
        apply(101, mk(1'b1, 1'b1, 4'hB, 2'b10, 2'b00, 1'b1, 2'b11, 4'h6, 4'hA, 1'b0));
        apply(102, mk(1'b1, 1'b1, 4'hC, 2'b10, 2'b00, 1'b0, 2'b11, 4'h6, 4'hA, 1'b0));
        apply(103, mk(1'b1, 1'b1, 4'h3, 2'b01, 2'b01, 1'b1, 2'b11, 4'h3, 4'hA, 1'b0));
        apply(104, mk(1'b1, 1'b0, 4'h0, 2'b10, 2'b10, 1'b0, 2'b11, 4'h3, 4'hB, 1'b0));
        apply(105, mk(1'b1, 1'b0, 4'h0, 2'b01, 2'b11, 1'b1, 2'b00, 4'h0, 4'h0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
